// File: rtl/binary_subtractor_8bit_serial_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives start/A/B/B_in; the subtractor returns busy/done/diff/B_out.
interface binary_subtractor_8bit_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             B_out;

  modport master (
    output start, A, B, B_in,
    input  busy, done, diff, B_out
  );

  modport slave (
    input  start, A, B, B_in,
    output busy, done, diff, B_out
  );
endinterface

// File: rtl/binary_subtractor_8bit_serial.sv
// Bit-serial A - B - B_in, LSB first; done pulses WIDTH edges after an accepted start.
// start is taken only in IDLE/DONE and dropped while shifting; results hold until the next completion.
module binary_subtractor_8bit_serial #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  binary_subtractor_8bit_serial_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             borrow;

  logic             d_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_nxt;

  // One full-subtractor cell; the result fills from the top so bit 0 lands at the LSB after WIDTH shifts.
  always_comb begin
    d_bit      = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    res_nxt    = {d_bit, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.diff   <= '0;
      bus.B_out  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (bus.start) begin
            state    <= SHIFT;
            a_sh     <= bus.A;
            b_sh     <= bus.B;
            borrow   <= bus.B_in;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res    <= res_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.diff  <= res_nxt;
            bus.B_out <= borrow_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_subtractor_8bit_serial.sv
// Randomised and directed bench for the serial subtractor, checked every cycle against
// a phase-counting arithmetic model plus hand-computed literal results.
module tb_binary_subtractor_8bit_serial;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  binary_subtractor_8bit_serial_if #(.WIDTH(W)) bus ();

  binary_subtractor_8bit_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase = edges since the accepting edge (-1 when idle); the answer is plain (W+1)-bit arithmetic.
  int         phase = -1;
  bit         model_live = 1'b0;
  logic [W:0] exp_res = '0;
  logic [W-1:0] pa, pb;
  logic       pbin;

  always @(posedge clk) begin
    if (rst) begin
      phase      = -1;
      exp_res    = '0;
      model_live = 1'b1;
    end else if ((phase < 0 || phase == W) && bus.start) begin
      phase = 0;
      pa    = bus.A;
      pb    = bus.B;
      pbin  = bus.B_in;
    end else if (phase >= 0 && phase < W) begin
      phase++;
      if (phase == W) exp_res = {1'b0, pa} - (W+1)'(pb) - (W+1)'(pbin);
    end else begin
      phase = -1;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("busy", 32'(bus.busy), 32'(phase >= 0 && phase < W));
      chk("done", 32'(bus.done), 32'(phase == W));
      chk("diff", 32'(bus.diff), 32'(exp_res[W-1:0]));
      chk("B_out", 32'(bus.B_out), 32'(exp_res[W]));
      chk("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
    end
  end

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.A    = a;
    bus.B    = b;
    bus.B_in = bin;
  endtask

  // Called right after the accepting edge's negedge; returns edges until done is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input int exp_d, input int exp_bo);
    int n;
    set_ops(a, b, bin);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk({nm, "_latency"}, 32'(n), 32'(W));
    chk({nm, "_diff"}, 32'(bus.diff), 32'(exp_d));
    chk({nm, "_bout"}, 32'(bus.B_out), 32'(exp_bo));
    @(negedge clk);
  endtask

  initial begin
    int n1, n2;
    bus.start = 1'b0;
    set_ops('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.B_out), 32'd0);
    @(negedge clk);

    run_op("t1", 8'd200, 8'd55, 1'b0, 145, 0);
    run_op("t2", 8'd55, 8'd200, 1'b0, 111, 1);

    // Reset mid-operation clears the held 111/1 result and suppresses done.
    set_ops(8'd100, 8'd1, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_diff", 32'(bus.diff), 32'd0);
    chk("t5_bout", 32'(bus.B_out), 32'd0);
    run_op("t5_fresh", 8'd100, 8'd1, 1'b0, 99, 0);

    run_op("t3a", 8'd0, 8'd0, 1'b1, 255, 1);
    run_op("t3b", 8'd0, 8'd255, 1'b1, 0, 1);

    // start held high throughout: re-accepted in the DONE cycle only.
    set_ops(8'd10, 8'd3, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    set_ops(8'd9, 8'd9, 1'b0);
    wait_done(n1);
    chk("t4_first_edge", 32'(n1), 32'd8);
    chk("t4_first_diff", 32'(bus.diff), 32'd7);
    chk("t4_first_bout", 32'(bus.B_out), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n2);
    chk("t4_second_edge", 32'(n1 + 1 + n2), 32'd17);
    chk("t4_second_diff", 32'(bus.diff), 32'd0);
    chk("t4_second_bout", 32'(bus.B_out), 32'd0);
    @(negedge clk);

    // Back-to-back random operations with junk start pulses and operand churn while shifting.
    for (int k = 0; k < 1000; k++) begin
      set_ops(W'($urandom), W'($urandom), 1'($urandom));
      bus.start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
        bus.start = 1'($urandom);
        set_ops(W'($urandom), W'($urandom), 1'($urandom));
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
